// File: rtl/zculling_stage.sv
// zculling_stage: depth-test stage that follows rasterization.
//
// A batch starts with an input header word, which carries the fragment count N
// and a CLR flag. N fragment words follow it. Each fragment is tested against
// an on-chip z-buffer. A fragment survives when its z is strictly less than the
// stored depth. A survivor updates the z-buffer and is queued, in arrival
// order, in a survivor buffer. The stage then emits an output header with the
// survivor count M, followed by the M queued pixels.
//
// Ports
//   ap_clk, ap_rst              clock, synchronous active-high reset
//   ap_start                    level start, sampled only in IDLE
//   ap_done                     pulse on the transfer of a batch's last output word
//   ap_idle                     high while waiting for ap_start
//   ap_ready                    pulse when the input header is accepted
//   Input_1_V_V[_ap_vld/_ap_ack]   input word stream
//   Output_1_V_V[_ap_vld/_ap_ack]  output word stream
//   dbg_state                   current FSM state, for observation
//
// Handshake: a word moves on a rising edge where vld and ack are both high.
// The producer holds the data stable while vld is high and ack is low.
// Input ack is raised only in HDR and FRAG_RD.
// Output vld is raised only in OUT_HDR and OUT_PIX.
module zculling_stage #(
    parameter int X_BITS    = 8,
    parameter int Y_BITS    = 8,
    parameter int MAX_FRAGS = 500,
    parameter int CNT_BITS  = 16
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [31:0] Input_1_V_V,
    input  logic        Input_1_V_V_ap_vld,
    output logic        Input_1_V_V_ap_ack,
    output logic [31:0] Output_1_V_V,
    output logic        Output_1_V_V_ap_vld,
    input  logic        Output_1_V_V_ap_ack,
    output logic [2:0]  dbg_state
);
    localparam int A_BITS = X_BITS + Y_BITS;
    localparam int DEPTH  = 1 << A_BITS;
    localparam int P_BITS = A_BITS + 8;
    localparam int S_BITS = $clog2(MAX_FRAGS + 1);
    localparam logic [S_BITS-1:0] MAX_CNT = S_BITS'(MAX_FRAGS);

    typedef enum logic [2:0] {
        S_CLEAR, S_IDLE, S_HDR, S_FRAG_RD, S_FRAG_WR, S_OUT_HDR, S_OUT_PIX, S_DONE
    } state_t;

    state_t state, state_next;

    logic [7:0]          zbuf [DEPTH];
    logic [7:0]          zbuf_q;
    logic                zbuf_we;
    logic [A_BITS-1:0]   zbuf_waddr;
    logic [7:0]          zbuf_wdata;
    logic [A_BITS-1:0]   zbuf_raddr;

    logic [P_BITS-1:0]   surv [MAX_FRAGS];
    logic [P_BITS-1:0]   surv_rd;
    logic                surv_we;

    logic [A_BITS-1:0]   clr_addr;
    logic                clr_ret;      // CLEAR was entered from a CLR header
    logic [CNT_BITS-1:0] remaining;
    logic [S_BITS-1:0]   surv_cnt;
    logic [S_BITS-1:0]   rd_ptr;
    logic [X_BITS-1:0]   frag_x;
    logic [Y_BITS-1:0]   frag_y;
    logic [7:0]          frag_z;
    logic [7:0]          frag_c;

    logic in_xfer, out_xfer, pass, last_pix;

    assign in_xfer  = Input_1_V_V_ap_vld && Input_1_V_V_ap_ack;
    assign out_xfer = Output_1_V_V_ap_vld && Output_1_V_V_ap_ack;
    assign pass     = frag_z < zbuf_q;
    assign last_pix = (rd_ptr + S_BITS'(1)) == surv_cnt;

    assign Input_1_V_V_ap_ack  = (state == S_HDR) || (state == S_FRAG_RD);
    assign Output_1_V_V_ap_vld = (state == S_OUT_HDR) || (state == S_OUT_PIX);
    assign ap_idle             = (state == S_IDLE);
    assign ap_ready            = (state == S_HDR) && Input_1_V_V_ap_vld;
    // ap_done follows the last transfer itself. DONE is then just the one-cycle
    // return path to IDLE.
    assign ap_done = out_xfer && (((state == S_OUT_HDR) && (surv_cnt == '0)) ||
                                  ((state == S_OUT_PIX) && last_pix));
    assign dbg_state = state;

    // The z-buffer is read with the address carried by the incoming fragment
    // word. Its data is therefore ready in FRAG_WR.
    assign zbuf_raddr = {Input_1_V_V[8 +: Y_BITS], Input_1_V_V[X_BITS-1:0]};

    always_comb begin
        zbuf_we    = 1'b0;
        zbuf_waddr = clr_addr;
        zbuf_wdata = 8'hFF;
        if (state == S_CLEAR) begin
            zbuf_we = 1'b1;
        end else if ((state == S_FRAG_WR) && pass && !ap_rst) begin
            zbuf_we    = 1'b1;
            zbuf_waddr = {frag_y, frag_x};
            zbuf_wdata = frag_z;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (zbuf_we) zbuf[zbuf_waddr] <= zbuf_wdata;
        zbuf_q <= zbuf[zbuf_raddr];
    end

    // Survivors beyond MAX_FRAGS still update the z-buffer but are not queued.
    assign surv_we = (state == S_FRAG_WR) && pass && (surv_cnt != MAX_CNT);

    always_ff @(posedge ap_clk) begin
        if (surv_we) surv[surv_cnt] <= {frag_c, frag_y, frag_x};
    end

    assign surv_rd = surv[rd_ptr];

    always_comb begin
        Output_1_V_V = '0;
        if (state == S_OUT_HDR) begin
            Output_1_V_V[S_BITS-1:0] = surv_cnt;
        end else if (state == S_OUT_PIX) begin
            Output_1_V_V[X_BITS-1:0]  = surv_rd[X_BITS-1:0];
            Output_1_V_V[8 +: Y_BITS] = surv_rd[X_BITS +: Y_BITS];
            Output_1_V_V[23:16]       = surv_rd[A_BITS +: 8];
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_CLEAR: begin
                if (clr_addr == '1) begin
                    if (!clr_ret)              state_next = S_IDLE;
                    else if (remaining == '0)  state_next = S_OUT_HDR;
                    else                       state_next = S_FRAG_RD;
                end
            end
            S_IDLE:    if (ap_start) state_next = S_HDR;
            S_HDR: begin
                if (in_xfer) begin
                    if (Input_1_V_V[31])                       state_next = S_CLEAR;
                    else if (Input_1_V_V[CNT_BITS-1:0] == '0)  state_next = S_OUT_HDR;
                    else                                       state_next = S_FRAG_RD;
                end
            end
            S_FRAG_RD: if (in_xfer) state_next = S_FRAG_WR;
            S_FRAG_WR: state_next = (remaining == CNT_BITS'(1)) ? S_OUT_HDR : S_FRAG_RD;
            S_OUT_HDR: if (out_xfer) state_next = (surv_cnt == '0) ? S_DONE : S_OUT_PIX;
            S_OUT_PIX: if (out_xfer && last_pix) state_next = S_DONE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_CLEAR;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state     <= S_CLEAR;
            clr_addr  <= '0;
            clr_ret   <= 1'b0;
            remaining <= '0;
            surv_cnt  <= '0;
            rd_ptr    <= '0;
            frag_x    <= '0;
            frag_y    <= '0;
            frag_z    <= '0;
            frag_c    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_CLEAR: begin
                    // The address wraps back to 0, ready for the next CLEAR.
                    clr_addr <= clr_addr + A_BITS'(1);
                    if (clr_addr == '1) clr_ret <= 1'b0;
                end
                S_HDR: begin
                    if (in_xfer) begin
                        remaining <= Input_1_V_V[CNT_BITS-1:0];
                        clr_ret   <= Input_1_V_V[31];
                        surv_cnt  <= '0;
                        rd_ptr    <= '0;
                    end
                end
                S_FRAG_RD: begin
                    if (in_xfer) begin
                        frag_x <= Input_1_V_V[X_BITS-1:0];
                        frag_y <= Input_1_V_V[8 +: Y_BITS];
                        frag_z <= Input_1_V_V[23:16];
                        frag_c <= Input_1_V_V[31:24];
                    end
                end
                S_FRAG_WR: begin
                    remaining <= remaining - CNT_BITS'(1);
                    if (surv_we) surv_cnt <= surv_cnt + S_BITS'(1);
                end
                S_OUT_PIX: if (out_xfer) rd_ptr <= rd_ptr + S_BITS'(1);
                default: ;
            endcase
        end
    end
endmodule
